ps2_light_ctrl: RTL and testbench
=================================

# ps2_light_ctrl

Command controller between the PS/2 keyboard receiver and the house-light outputs. It consumes received scan-code bytes (set 2) and tracks make, break (F0) and extended (E0) prefixes. It converts key presses into per-zone light toggles and all-on/all-off commands, and suppresses typematic auto-repeat. It sits directly downstream of the receiver, replacing the raw byte-to-LED path.

## Interface
- PREFIX_TIMEOUT, 50000: clock cycles a prefix state may wait for its next byte before being abandoned.
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- rx_valid  in  1  one-cycle strobe: rx_data holds a new received byte.
- rx_data  in  8  received scan-code byte; sampled only when rx_valid=1.
- lights  out  8  light zone enables; bit z = zone z.
- cmd_pulse  out  1  one-cycle strobe whenever lights changes.
- err_pulse  out  1  one-cycle strobe on prefix timeout or unmapped code in IDLE.

## Operation
- Zone keys (make codes) map to zones 0..7: '1'=16h, '2'=1Eh, '3'=26h, '4'=25h, '5'=2Eh, '6'=36h, '7'=3Dh, '8'=3Eh.
- Extended keys: E0 75 (up arrow) sets all lights to FFh; E0 72 (down arrow) sets all lights to 00h.
- Internal held[7:0] holds one bit per zone key. held_up and held_dn hold one bit each for the extended keys.
- States and transitions (evaluated only on cycles with rx_valid=1):
  - IDLE:
    - F0h -> BRK.
    - E0h -> EXT.
    - Zone code z with held[z]=0: toggle lights[z], set held[z], pulse cmd_pulse.
    - Zone code z with held[z]=1: no action (typematic repeat).
    - Any other byte: pulse err_pulse, stay in IDLE.
  - BRK: zone code z clears held[z]. Any byte, including E0h/F0h, is consumed and returns to IDLE. No err_pulse.
  - EXT:
    - F0h -> EXT_BRK.
    - 75h with held_up=0: lights<=FFh, set held_up, cmd_pulse if the value changed.
    - 72h with held_dn=0: lights<=00h, set held_dn, cmd_pulse if the value changed.
    - Any other byte: ignored.
    - Every byte except F0h returns to IDLE.
  - EXT_BRK: 75h clears held_up; 72h clears held_dn. Any byte returns to IDLE.
- Prefix timer:
  - Counts cycles while in BRK, EXT or EXT_BRK.
  - Cleared on every accepted byte and on entry to IDLE.
  - When it reaches PREFIX_TIMEOUT-1 with no rx_valid that cycle: go to IDLE and pulse err_pulse. held bits are unchanged.
- The F0h/E0h bytes themselves never change lights.

## Timing
- Reset values: lights=00h, cmd_pulse=0, err_pulse=0, state=IDLE, held/held_up/held_dn=0, timer=0.
- Latency: lights, cmd_pulse and err_pulse update on the clock edge that samples rx_valid=1, so they are visible the following cycle.
- cmd_pulse and err_pulse are high for exactly one cycle and never assert together.
- rx_valid may assert on consecutive cycles; each byte is processed fully in one cycle. No backpressure.
- rx_valid coincident with timer expiry: the byte is processed in the current state and the timeout is ignored.
- Reset asserted mid-prefix: reset dominates, returning to IDLE with all held bits cleared.
- Timer width: ceil(log2(PREFIX_TIMEOUT)) bits; saturation is not needed because expiry forces IDLE.

## Structure
- Shared package ps2_light_pkg:
  - State enum (IDLE, BRK, EXT, EXT_BRK).
  - Scan-code constants: F0h, E0h, zone codes, 75h, 72h.
  - Function zone_of(code) returning {hit, idx[2:0]}.
- No sub-module. The byte decoder is the package function; the FSM, timer and held registers live in this block.

## Test plan
- Reset, then send 16h -> lights=01h, one cmd_pulse. Then send 16h again -> lights stays 01h, no pulse. Then send F0 16 then 16 -> lights=00h.
- Send E0 75 -> lights=FFh with cmd_pulse. Send E0 F0 75, then E0 72 -> lights=00h. Send E0 72 again while held (no break sent) -> no change.
- Send byte 1Ch in IDLE -> err_pulse once, lights unchanged. Send F0 1C -> no err_pulse.
- With PREFIX_TIMEOUT=16, send F0 and idle 15 cycles -> err_pulse, state IDLE. Then send 1Eh -> lights bit1 set.
- Send F0, then drive rx_valid with 1Eh exactly on the expiry cycle -> treated as a break: held[1] cleared, no err_pulse.
- Assert reset after E0 -> next byte 75h in IDLE gives err_pulse, and lights=00h.

Source files
------------

// File: rtl/ps2_light_pkg.sv
// Shared types, scan-code constants and the zone decoder
// for the PS/2 house-light command controller.
package ps2_light_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BRK,
    EXT,
    EXT_BRK
  } state_e;

  localparam logic [7:0] SC_BRK  = 8'hF0;
  localparam logic [7:0] SC_EXT  = 8'hE0;
  localparam logic [7:0] SC_UP   = 8'h75;
  localparam logic [7:0] SC_DN   = 8'h72;
  localparam logic [7:0] SC_Z0   = 8'h16;
  localparam logic [7:0] SC_Z1   = 8'h1E;
  localparam logic [7:0] SC_Z2   = 8'h26;
  localparam logic [7:0] SC_Z3   = 8'h25;
  localparam logic [7:0] SC_Z4   = 8'h2E;
  localparam logic [7:0] SC_Z5   = 8'h36;
  localparam logic [7:0] SC_Z6   = 8'h3D;
  localparam logic [7:0] SC_Z7   = 8'h3E;

  // Returns {hit, idx[2:0]}; hit=0 for non-zone codes.
  function automatic logic [3:0] zone_of(
    input logic [7:0] code
  );
    logic [3:0] r;
    r = 4'b0000;
    case (code)
      SC_Z0:   r = 4'b1000;
      SC_Z1:   r = 4'b1001;
      SC_Z2:   r = 4'b1010;
      SC_Z3:   r = 4'b1011;
      SC_Z4:   r = 4'b1100;
      SC_Z5:   r = 4'b1101;
      SC_Z6:   r = 4'b1110;
      SC_Z7:   r = 4'b1111;
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_light_ctrl.sv
// Scan-code (set 2) to light-zone command controller with
// break/extended prefix tracking and typematic suppression.
module ps2_light_ctrl
  import ps2_light_pkg::*;
#(
  parameter int PREFIX_TIMEOUT = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic [7:0] lights,
  output logic       cmd_pulse,
  output logic       err_pulse
);

  localparam int TW =
    (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX =
    TW'(PREFIX_TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [7:0]    lights_q, lights_d;
  logic [7:0]    held_q, held_d;
  logic          held_up_q, held_up_d;
  logic          held_dn_q, held_dn_d;
  logic          cmd_q, cmd_d;
  logic          err_q, err_d;
  logic [TW-1:0] timer_q, timer_d;

  logic [3:0] zone;
  logic       hit;
  logic [2:0] idx;

  assign zone = zone_of(rx_data);
  assign hit  = zone[3];
  assign idx  = zone[2:0];

  always_comb begin
    state_d   = state_q;
    lights_d  = lights_q;
    held_d    = held_q;
    held_up_d = held_up_q;
    held_dn_d = held_dn_q;
    cmd_d     = 1'b0;
    err_d     = 1'b0;
    timer_d   = (state_q == IDLE) ? '0 : timer_q + 1'b1;
    if (rx_valid) begin
      timer_d = '0;
      case (state_q)
        IDLE: begin
          if (rx_data == SC_BRK) begin
            state_d = BRK;
          end else if (rx_data == SC_EXT) begin
            state_d = EXT;
          end else if (hit) begin
            if (!held_q[idx]) begin
              lights_d[idx] = ~lights_q[idx];
              held_d[idx]   = 1'b1;
              cmd_d         = 1'b1;
            end
          end else begin
            err_d = 1'b1;
          end
        end
        BRK: begin
          if (hit) held_d[idx] = 1'b0;
          state_d = IDLE;
        end
        EXT: begin
          if (rx_data == SC_BRK) begin
            state_d = EXT_BRK;
          end else begin
            state_d = IDLE;
            if (rx_data == SC_UP && !held_up_q) begin
              lights_d  = 8'hFF;
              held_up_d = 1'b1;
              cmd_d     = (lights_q != 8'hFF);
            end else if (rx_data == SC_DN && !held_dn_q) begin
              lights_d  = 8'h00;
              held_dn_d = 1'b1;
              cmd_d     = (lights_q != 8'h00);
            end
          end
        end
        EXT_BRK: begin
          if (rx_data == SC_UP) held_up_d = 1'b0;
          if (rx_data == SC_DN) held_dn_d = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && timer_q == TMAX) begin
      // Abandoned prefix: drop back, keep held bits.
      state_d = IDLE;
      timer_d = '0;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      lights_q  <= 8'h00;
      held_q    <= 8'h00;
      held_up_q <= 1'b0;
      held_dn_q <= 1'b0;
      cmd_q     <= 1'b0;
      err_q     <= 1'b0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      lights_q  <= lights_d;
      held_q    <= held_d;
      held_up_q <= held_up_d;
      held_dn_q <= held_dn_d;
      cmd_q     <= cmd_d;
      err_q     <= err_d;
      timer_q   <= timer_d;
    end
  end

  assign lights    = lights_q;
  assign cmd_pulse = cmd_q;
  assign err_pulse = err_q;

endmodule

// File: tb/tb_ps2_light_ctrl.sv
// Scoreboard bench for ps2_light_ctrl: expected pulses are
// queued at stimulus time and popped by a monitor.
module tb_ps2_light_ctrl;

  typedef struct {
    bit         is_err;
    logic [7:0] lights;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [7:0] lights;
  logic       cmd_pulse;
  logic       err_pulse;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  bit   done = 1'b0;

  ps2_light_ctrl #(.PREFIX_TIMEOUT(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .lights    (lights),
    .cmd_pulse (cmd_pulse),
    .err_pulse (err_pulse)
  );

  always #5 clock = ~clock;

  task automatic expect_cmd(input logic [7:0] l);
    exp_t e;
    e.is_err = 1'b0;
    e.lights = l;
    exp_q.push_back(e);
  endtask

  task automatic expect_err(input logic [7:0] l);
    exp_t e;
    e.is_err = 1'b1;
    e.lights = l;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clock);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic chk(
    input string      name,
    input logic [7:0] act,
    input logic [7:0] req
  );
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h",
               name, act, req);
    end
  endtask

  // Monitor: every observed pulse must match the queue head.
  always @(negedge clock) begin
    if (!reset && !done && (cmd_pulse || err_pulse)) begin
      exp_t e;
      checks++;
      if (cmd_pulse && err_pulse) begin
        failures++;
        $display("FAIL both_pulses: cmd=1 err=1 at %0t",
                 $time);
      end else if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse: cmd=%0b err=%0b lights=%02h, none expected",
                 cmd_pulse, err_pulse, lights);
      end else begin
        e = exp_q.pop_front();
        if (e.is_err != err_pulse || e.lights !== lights) begin
          failures++;
          $display("FAIL pulse: got err=%0b lights=%02h expected err=%0b lights=%02h",
                   err_pulse, lights, e.is_err, e.lights);
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clock);
    chk("reset_lights", lights, 8'h00);
    chk("reset_cmd", {7'd0, cmd_pulse}, 8'h00);
    chk("reset_err", {7'd0, err_pulse}, 8'h00);
    reset = 1'b0;
    @(negedge clock);

    // Zone toggle, typematic repeat, break then re-press.
    expect_cmd(8'h01);
    send(8'h16);
    send(8'h16);
    send(8'hF0);
    send(8'h16);
    expect_cmd(8'h00);
    send(8'h16);
    @(negedge clock);
    chk("zone0_off", lights, 8'h00);

    // Extended up/down with held suppression.
    expect_cmd(8'hFF);
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    expect_cmd(8'h00);
    send(8'hE0); send(8'h72);
    send(8'hE0); send(8'h72);
    @(negedge clock);
    chk("down_held", lights, 8'h00);
    // Release down, press again: value unchanged, no pulse.
    send(8'hE0); send(8'hF0); send(8'h72);
    send(8'hE0); send(8'h72);
    // Same-value up after re-press check: up goes to FF.
    expect_cmd(8'hFF);
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h72);
    expect_cmd(8'h00);
    send(8'hE0); send(8'h72);
    @(negedge clock);
    chk("ext_sequence", lights, 8'h00);

    // Unmapped code in IDLE vs inside a break.
    expect_err(8'h00);
    send(8'h1C);
    send(8'hF0); send(8'h1C);
    @(negedge clock);
    chk("unmapped_lights", lights, 8'h00);

    // Prefix timeout: 16 idle edges after the F0 edge.
    send(8'hF0);
    expect_err(8'h00);
    repeat (16) @(negedge clock);
    expect_cmd(8'h02);
    send(8'h1E);
    @(negedge clock);
    chk("after_timeout", lights, 8'h02);

    // Byte lands on the expiry edge: processed as a break.
    send(8'hF0);
    repeat (15) @(negedge clock);
    send(8'h1E);
    expect_cmd(8'h00);
    send(8'h1E);
    @(negedge clock);
    chk("expiry_break", lights, 8'h00);

    // Reset in the middle of an extended prefix.
    expect_cmd(8'h04);
    send(8'h26);
    chk("zone2_on", lights, 8'h04);
    send(8'hE0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("reset_mid_lights", lights, 8'h00);
    expect_err(8'h00);
    send(8'h75);
    expect_cmd(8'h04);
    send(8'h26);
    repeat (3) @(negedge clock);
    chk("final_lights", lights, 8'h04);

    done = 1'b1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_pulses: %0d pending, expected 0",
               exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
